// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MIPS memory stage: data memory plus MEM/WB pipeline register
//
// Purpose:
//   Performs word loads/stores against a 2**DEPTH_LOG2-word data memory and
//   holds the MEM/WB pipeline register feeding the register file and the
//   execution stage's forwarding paths.
//
// Ports:
//   CLK, RST          clock; synchronous active-high reset
//   RegWriteM         register-write control from EX/MEM
//   MemToRegM         load select from EX/MEM
//   MemWriteM         store enable from EX/MEM
//   ALUresultM[31:0]  byte address for loads/stores, or ALU result
//   WriteDataM[31:0]  store data
//   WriteRegM[4:0]    destination register
//   StallM            hold MEM/WB and suppress the store this cycle
//   FlushW            insert a bubble into MEM/WB
//   RegWriteW         registered register-file write enable
//   MemToRegW         registered load select
//   ReadDataW[31:0]   registered load data
//   ALUresultW[31:0]  registered ALU result
//   WriteRegW[4:0]    registered destination register
//   resultW[31:0]     MemToRegW ? ReadDataW : ALUresultW (combinational)
//   AlignFault        sticky misaligned-access flag, cleared only by RST

module mem_wb_stage #(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        RegWriteM,
   input  logic        MemToRegM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUresultM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  WriteRegM,
   input  logic        StallM,
   input  logic        FlushW,
   output logic        RegWriteW,
   output logic        MemToRegW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUresultW,
   output logic [4:0]  WriteRegW,
   output logic [31:0] resultW,
   output logic        AlignFault
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // Data memory: no reset, contents undefined until written.
   logic [31:0] mem_q [DEPTH];

   logic [DEPTH_LOG2-1:0] word_idx;
   logic                  in_range;
   logic                  aligned;
   logic                  misaligned_access;
   logic                  store_en;
   logic [31:0]           read_data;

   logic        reg_write_q,   reg_write_d;
   logic        mem_to_reg_q,  mem_to_reg_d;
   logic [31:0] read_data_q,   read_data_d;
   logic [31:0] alu_result_q,  alu_result_d;
   logic [4:0]  write_reg_q,   write_reg_d;
   logic        align_fault_q, align_fault_d;

   assign word_idx = ALUresultM[DEPTH_LOG2+1:2];
   assign in_range = (ALUresultM[31:DEPTH_LOG2+2] == '0);
   assign aligned  = (ALUresultM[1:0] == 2'b00);

   // Stalled accesses are not considered executed, so they cannot fault.
   assign misaligned_access = (MemWriteM | MemToRegM) & ~aligned & ~StallM;

   assign store_en = MemWriteM & ~StallM & aligned & in_range & ~RST;

   // Asynchronous read sampled at the same edge as the write, which gives
   // read-before-write semantics for same-word load/store in one cycle.
   assign read_data = (in_range && aligned) ? mem_q[word_idx] : 32'h0;

   always_ff @(posedge CLK) begin
      if (store_en) begin
         mem_q[word_idx] <= WriteDataM;
      end
   end

   // MEM/WB next state: flush beats stall beats capture.
   always_comb begin
      reg_write_d   = reg_write_q;
      mem_to_reg_d  = mem_to_reg_q;
      read_data_d   = read_data_q;
      alu_result_d  = alu_result_q;
      write_reg_d   = write_reg_q;
      align_fault_d = align_fault_q | misaligned_access;

      if (FlushW) begin
         reg_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
      end else if (!StallM) begin
         reg_write_d  = RegWriteM;
         mem_to_reg_d = MemToRegM;
         read_data_d  = read_data;
         alu_result_d = ALUresultM;
         write_reg_d  = WriteRegM;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         reg_write_q   <= 1'b0;
         mem_to_reg_q  <= 1'b0;
         read_data_q   <= 32'h0;
         alu_result_q  <= 32'h0;
         write_reg_q   <= 5'd0;
         align_fault_q <= 1'b0;
      end else begin
         reg_write_q   <= reg_write_d;
         mem_to_reg_q  <= mem_to_reg_d;
         read_data_q   <= read_data_d;
         alu_result_q  <= alu_result_d;
         write_reg_q   <= write_reg_d;
         align_fault_q <= align_fault_d;
      end
   end

   assign RegWriteW  = reg_write_q;
   assign MemToRegW  = mem_to_reg_q;
   assign ReadDataW  = read_data_q;
   assign ALUresultW = alu_result_q;
   assign WriteRegW  = write_reg_q;
   assign AlignFault = align_fault_q;
   assign resultW    = mem_to_reg_q ? read_data_q : alu_result_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - table-driven self-checking bench for mem_wb_stage

module tb_mem_wb_stage;

   logic        CLK;
   logic        RST;
   logic        RegWriteM;
   logic        MemToRegM;
   logic        MemWriteM;
   logic [31:0] ALUresultM;
   logic [31:0] WriteDataM;
   logic [4:0]  WriteRegM;
   logic        StallM;
   logic        FlushW;
   logic        RegWriteW;
   logic        MemToRegW;
   logic [31:0] ReadDataW;
   logic [31:0] ALUresultW;
   logic [4:0]  WriteRegW;
   logic [31:0] resultW;
   logic        AlignFault;

   mem_wb_stage #(.DEPTH_LOG2(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RegWriteM  (RegWriteM),
      .MemToRegM  (MemToRegM),
      .MemWriteM  (MemWriteM),
      .ALUresultM (ALUresultM),
      .WriteDataM (WriteDataM),
      .WriteRegM  (WriteRegM),
      .StallM     (StallM),
      .FlushW     (FlushW),
      .RegWriteW  (RegWriteW),
      .MemToRegW  (MemToRegW),
      .ReadDataW  (ReadDataW),
      .ALUresultW (ALUresultW),
      .WriteRegW  (WriteRegW),
      .resultW    (resultW),
      .AlignFault (AlignFault)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic        rst, rw, m2r, mw, stall, flush;
      logic [31:0] alu, wd;
      logic [4:0]  wr;
      logic        chk_data, chk_rd;
      logic        e_rw, e_m2r;
      logic [31:0] e_rd, e_alu, e_res;
      logic [4:0]  e_wr;
      logic        e_af;
   } vec_t;

   int n_vec  = 0;
   int n_fail = 0;
   vec_t tbl[$];

   function automatic vec_t mkv(
      input logic rst, input logic rw, input logic m2r, input logic mw,
      input logic stall, input logic flush,
      input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
      input logic chk_data, input logic chk_rd,
      input logic e_rw, input logic e_m2r, input logic [31:0] e_rd,
      input logic [31:0] e_alu, input logic [4:0] e_wr, input logic [31:0] e_res,
      input logic e_af);
      vec_t v;
      v.rst = rst; v.rw = rw; v.m2r = m2r; v.mw = mw; v.stall = stall; v.flush = flush;
      v.alu = alu; v.wd = wd; v.wr = wr;
      v.chk_data = chk_data; v.chk_rd = chk_rd;
      v.e_rw = e_rw; v.e_m2r = e_m2r; v.e_rd = e_rd; v.e_alu = e_alu;
      v.e_wr = e_wr; v.e_res = e_res; v.e_af = e_af;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   // Drive one M-stage cycle, clock it, then check the W outputs 1 ns later.
   task automatic apply(input vec_t v, input int idx);
      RST        = v.rst;
      RegWriteM  = v.rw;
      MemToRegM  = v.m2r;
      MemWriteM  = v.mw;
      StallM     = v.stall;
      FlushW     = v.flush;
      ALUresultM = v.alu;
      WriteDataM = v.wd;
      WriteRegM  = v.wr;
      @(posedge CLK);
      #1;
      n_vec++;
      chk("RegWriteW", idx, {31'b0, RegWriteW}, {31'b0, v.e_rw});
      chk("MemToRegW", idx, {31'b0, MemToRegW}, {31'b0, v.e_m2r});
      chk("AlignFault", idx, {31'b0, AlignFault}, {31'b0, v.e_af});
      if (v.chk_data) begin
         chk("ALUresultW", idx, ALUresultW, v.e_alu);
         chk("WriteRegW", idx, {27'b0, WriteRegW}, {27'b0, v.e_wr});
         if (v.chk_rd) begin
            chk("ReadDataW", idx, ReadDataW, v.e_rd);
            chk("resultW", idx, resultW, v.e_res);
         end
      end
      #3;
   endtask

   initial begin
      RST = 1'b1; RegWriteM = 1'b0; MemToRegM = 1'b0; MemWriteM = 1'b0;
      StallM = 1'b0; FlushW = 1'b0; ALUresultM = '0; WriteDataM = '0; WriteRegM = '0;
      #2;

      //            rst rw m2r mw st fl alu           wd            wr  cd cr  erw em2r erd           ealu          ewr eres          eaf
      tbl.push_back(mkv(1, 1, 1, 1, 0, 0, 32'h44,       32'h99,       3,  1, 1,  0, 0, 32'h0,        32'h0,        0,  32'h0,        0));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 32'h10,       32'hDEADBEEF, 0,  1, 0,  0, 0, 32'h0,        32'h10,       0,  32'h10,       0));
      tbl.push_back(mkv(0, 1, 1, 0, 0, 0, 32'h10,       32'h0,        5,  1, 1,  1, 1, 32'hDEADBEEF, 32'h10,       5,  32'hDEADBEEF, 0));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 32'h20,       32'hDEADBEEF, 0,  1, 0,  0, 0, 32'h0,        32'h20,       0,  32'h20,       0));
      tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 32'h1234,     32'h0,        9,  1, 1,  1, 0, 32'h0,        32'h1234,     9,  32'h1234,     0));
      tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 32'h20,       32'h55,       0,  1, 1,  1, 0, 32'h0,        32'h1234,     9,  32'h1234,     0));
      tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 32'h20,       32'h55,       0,  1, 1,  1, 0, 32'h0,        32'h1234,     9,  32'h1234,     0));
      tbl.push_back(mkv(0, 1, 1, 0, 0, 0, 32'h20,       32'h0,        3,  1, 1,  1, 1, 32'hDEADBEEF, 32'h20,       3,  32'hDEADBEEF, 0));
      tbl.push_back(mkv(0, 1, 1, 0, 0, 1, 32'h20,       32'h0,        3,  0, 0,  0, 0, 32'h0,        32'h0,        0,  32'h0,        0));
      tbl.push_back(mkv(0, 1, 1, 0, 1, 1, 32'h20,       32'h0,        3,  0, 0,  0, 0, 32'h0,        32'h0,        0,  32'h0,        0));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 32'h0,        32'h12345678, 0,  1, 0,  0, 0, 32'h0,        32'h0,        0,  32'h0,        0));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 32'h400,      32'hAAAA,     0,  1, 1,  0, 0, 32'h0,        32'h400,      0,  32'h400,      0));
      tbl.push_back(mkv(0, 1, 1, 0, 0, 0, 32'h400,      32'h0,        7,  1, 1,  1, 1, 32'h0,        32'h400,      7,  32'h0,        0));
      tbl.push_back(mkv(0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        8,  1, 1,  1, 1, 32'h12345678, 32'h0,        8,  32'h12345678, 0));
      tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 32'h42,       32'h0,        0,  1, 1,  1, 0, 32'h0,        32'h42,       0,  32'h42,       0));

      foreach (tbl[i]) apply(tbl[i], i);

      // Misaligned store: dropped, fault sticky across idle cycles, reset clears it.
      apply(mkv(0, 0, 0, 1, 0, 0, 32'h22, 32'h99, 0, 1, 1, 0, 0, 32'h0, 32'h22, 0, 32'h22, 1), 100);
      for (int k = 0; k < 10; k++)
         apply(mkv(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 1, 0, 0, 32'h12345678, 32'h0, 0, 32'h0, 1), 101 + k);
      apply(mkv(0, 1, 1, 0, 0, 0, 32'h20, 32'h0, 4, 1, 1, 1, 1, 32'hDEADBEEF, 32'h20, 4, 32'hDEADBEEF, 1), 111);
      apply(mkv(0, 1, 1, 0, 0, 0, 32'h21, 32'h0, 4, 1, 1, 1, 1, 32'h0, 32'h21, 4, 32'h0, 1), 112);
      apply(mkv(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0), 113);

      // A stalled misaligned access is not executed and must not fault.
      apply(mkv(0, 1, 0, 1, 1, 0, 32'h22, 32'h99, 2, 1, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0), 200);
      apply(mkv(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 1, 0, 0, 32'h12345678, 32'h0, 0, 32'h0, 0), 201);

      // Reset in the same cycle as a store drops the store.
      apply(mkv(0, 0, 0, 1, 0, 0, 32'h30, 32'h11, 0, 1, 0, 0, 0, 32'h0, 32'h30, 0, 32'h30, 0), 300);
      apply(mkv(1, 1, 1, 1, 0, 0, 32'h30, 32'h77, 6, 1, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0), 301);
      apply(mkv(0, 1, 1, 0, 0, 0, 32'h30, 32'h0, 6, 1, 1, 1, 1, 32'h11, 32'h30, 6, 32'h11, 0), 302);

      // Same-word load and store in one cycle returns the old word.
      apply(mkv(0, 1, 1, 1, 0, 0, 32'h30, 32'h5, 2, 1, 1, 1, 1, 32'h11, 32'h30, 2, 32'h11, 0), 400);
      apply(mkv(0, 1, 1, 0, 0, 0, 32'h30, 32'h0, 2, 1, 1, 1, 1, 32'h5, 32'h30, 2, 32'h5, 0), 401);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
